// File: rtl/luhn_pkg.sv
// Shared types and helpers for the streaming Luhn checker.
// State encoding, digit-doubling table and mod-10 arithmetic used by
// luhn_dual_acc and luhn_stream_engine.
package luhn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } luhn_state_e;

  // dbl(d) = 2d, minus 9 when 2d exceeds 9
  localparam logic [3:0] DBL_LUT [0:9] = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8,
                                           4'd1, 4'd3, 4'd5, 4'd7, 4'd9};

  // Both operands are already reduced (0..9), so one conditional subtract suffices.
  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) begin
      s = s - 5'd10;
    end else begin
      s = s;
    end
    return s[3:0];
  endfunction

  // Doubled value of a BCD digit; non-BCD codes map to 0 and are never accumulated.
  function automatic logic [3:0] dbl_digit(input logic [3:0] d);
    logic [3:0] r;
    if (d <= 4'd9) begin
      r = DBL_LUT[d];
    end else begin
      r = 4'd0;
    end
    return r;
  endfunction

  // (10 - s) % 10 for a reduced sum s.
  function automatic logic [3:0] neg_mod10(input logic [3:0] s);
    logic [3:0] r;
    if (s == 4'd0) begin
      r = 4'd0;
    end else begin
      r = 4'd10 - s;
    end
    return r;
  endfunction

endpackage

// File: rtl/luhn_dual_acc.sv
// Dual mod-10 Luhn accumulator.
// sum_o doubles digits at odd 1-based positions, sum_e doubles digits at even
// positions. Keeping both lets the final length pick the right one without
// buffering the digits.
module luhn_dual_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] digit,
  output logic [3:0] sum_o,
  output logic [3:0] sum_e
);
  import luhn_pkg::*;

  logic [3:0] sum_o_r;
  logic [3:0] sum_e_r;
  logic       even_pos_r;   // 1 when the next digit sits at an even position
  logic [3:0] dbl_s;

  // Doubled form of the incoming digit.
  always_comb begin
    dbl_s = dbl_digit(digit);
  end

  // Fold the accepted digit into both sums and advance the position parity.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum_o_r    <= 4'd0;
      sum_e_r    <= 4'd0;
      even_pos_r <= 1'b0;
    end else if (en) begin
      if (!even_pos_r) begin
        sum_o_r <= add_mod10(sum_o_r, dbl_s);
        sum_e_r <= add_mod10(sum_e_r, digit);
      end else begin
        sum_o_r <= add_mod10(sum_o_r, digit);
        sum_e_r <= add_mod10(sum_e_r, dbl_s);
      end
      even_pos_r <= ~even_pos_r;
    end
  end

  assign sum_o = sum_o_r;
  assign sum_e = sum_e_r;

endmodule

// File: rtl/luhn_stream_engine.sv
// Streaming Luhn checker: one BCD digit per cycle, no PAN buffer.
// Holds the control FSM, the length counter and the result latches; the
// running sums live in luhn_dual_acc.
// Optional feature: define LUHN_GEN_EN to add check_digit generation.
module luhn_stream_engine #(
  parameter int MIN_DIGITS = 12,
  parameter int MAX_DIGITS = 19,
  parameter int LEN_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             digit_valid,
  input  logic [3:0]       digit_in,
  input  logic             pan_end,
  input  logic             abort,
  output logic             busy,
  output logic [LEN_W-1:0] len_count,
  output logic             done,
  output logic [LEN_W-1:0] len_final,
  output logic             length_ok,
  output logic             luhn_valid,
  output logic             error_flag
`ifdef LUHN_GEN_EN
  ,
  output logic [3:0]       check_digit
`endif
);
  import luhn_pkg::*;

  luhn_state_e      state_r;
  logic             busy_r;
  logic [LEN_W-1:0] len_count_r;
  logic             done_r;
  logic [LEN_W-1:0] len_final_r;
  logic             length_ok_r;
  logic             luhn_valid_r;
  logic             error_flag_r;

  logic             in_accum_s;
  logic             bcd_ok_s;
  logic             full_s;
  logic             bad_digit_s;
  logic             overflow_s;
  logic             accept_s;
  logic             clr_s;
  logic [3:0]       sum_o_s;
  logic [3:0]       sum_e_s;
  logic [3:0]       dbl_s;
  logic [3:0]       sum_o_fin_s;
  logic [3:0]       sum_e_fin_s;
  logic [LEN_W-1:0] n_s;
  logic             len_ok_s;
  logic [3:0]       sel_sum_s;
  logic             luhn_ok_s;
  logic             stray_s;

`ifdef LUHN_GEN_EN
  logic [3:0]       check_digit_r;
  logic [3:0]       gen_s;
`endif

  luhn_dual_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .en    (accept_s),
    .digit (digit_in),
    .sum_o (sum_o_s),
    .sum_e (sum_e_s)
  );

  // Classify the current digit and derive accumulator controls.
  always_comb begin
    in_accum_s  = (state_r == ACCUM) && !abort && !start;
    bcd_ok_s    = (digit_in <= 4'd9);
    full_s      = (len_count_r >= LEN_W'(MAX_DIGITS));
    bad_digit_s = in_accum_s && digit_valid && !bcd_ok_s;
    overflow_s  = in_accum_s && digit_valid && bcd_ok_s && full_s;
    accept_s    = in_accum_s && digit_valid && bcd_ok_s && !full_s;
    clr_s       = start || abort;
    stray_s     = digit_valid || pan_end;
  end

  // Sums and length including a digit that arrives together with pan_end,
  // so the result can be latched on the pan_end edge.
  always_comb begin
    dbl_s = dbl_digit(digit_in);
    if (accept_s) begin
      if (!len_count_r[0]) begin
        sum_o_fin_s = add_mod10(sum_o_s, dbl_s);
        sum_e_fin_s = add_mod10(sum_e_s, digit_in);
      end else begin
        sum_o_fin_s = add_mod10(sum_o_s, digit_in);
        sum_e_fin_s = add_mod10(sum_e_s, dbl_s);
      end
      n_s = len_count_r + LEN_W'(1);
    end else begin
      sum_o_fin_s = sum_o_s;
      sum_e_fin_s = sum_e_s;
      n_s         = len_count_r;
    end
    len_ok_s  = (n_s >= LEN_W'(MIN_DIGITS)) && (n_s <= LEN_W'(MAX_DIGITS));
    // Even length: the rightmost digit is at an even position, so odd positions are doubled.
    sel_sum_s = n_s[0] ? sum_e_fin_s : sum_o_fin_s;
    luhn_ok_s = len_ok_s && (sel_sum_s == 4'd0);
  end

`ifdef LUHN_GEN_EN
  // Check digit that would occupy position N+1 after an N-digit payload.
  always_comb begin
    gen_s = n_s[0] ? neg_mod10(sum_o_fin_s) : neg_mod10(sum_e_fin_s);
  end
`endif

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      len_count_r  <= '0;
      done_r       <= 1'b0;
      len_final_r  <= '0;
      length_ok_r  <= 1'b0;
      luhn_valid_r <= 1'b0;
      error_flag_r <= 1'b0;
`ifdef LUHN_GEN_EN
      check_digit_r <= 4'd0;
`endif
    end else begin
      done_r <= 1'b0;
      if (abort || start) begin
        state_r      <= abort ? IDLE : ACCUM;
        busy_r       <= !abort;
        len_count_r  <= '0;
        len_final_r  <= '0;
        length_ok_r  <= 1'b0;
        luhn_valid_r <= 1'b0;
        error_flag_r <= 1'b0;
`ifdef LUHN_GEN_EN
        check_digit_r <= 4'd0;
`endif
      end else begin
        case (state_r)
          ACCUM: begin
            if (bad_digit_s) begin
              state_r      <= ERR;
              busy_r       <= 1'b0;
              error_flag_r <= 1'b1;
            end else if (overflow_s) begin
              state_r      <= ERR;
              busy_r       <= 1'b0;
              error_flag_r <= 1'b1;
              len_count_r  <= LEN_W'(MAX_DIGITS + 1);
            end else begin
              len_count_r <= n_s;
              if (pan_end) begin
                state_r      <= DONE;
                busy_r       <= 1'b0;
                done_r       <= 1'b1;
                len_final_r  <= n_s;
                length_ok_r  <= len_ok_s;
                luhn_valid_r <= luhn_ok_s;
`ifdef LUHN_GEN_EN
                check_digit_r <= gen_s;
`endif
              end
            end
          end
          DONE: begin
            state_r <= IDLE;
            if (stray_s) begin
              error_flag_r <= 1'b1;
            end
          end
          IDLE, ERR: begin
            if (stray_s) begin
              error_flag_r <= 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy       = busy_r;
  assign len_count  = len_count_r;
  assign done       = done_r;
  assign len_final  = len_final_r;
  assign length_ok  = length_ok_r;
  assign luhn_valid = luhn_valid_r;
  assign error_flag = error_flag_r;
`ifdef LUHN_GEN_EN
  assign check_digit = check_digit_r;
`endif

endmodule

// File: tb/tb_luhn_stream_engine.sv
// Scoreboard bench for luhn_stream_engine: expected results are queued when
// pan_end is issued and popped by a monitor on every done pulse.
// Build with LUHN_GEN_EN defined to also check check_digit.
module tb_luhn_stream_engine;

  localparam int MIN_D = 12;
  localparam int MAX_D = 19;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          digit_valid;
  logic [3:0]    digit_in;
  logic          pan_end;
  logic          abort;
  logic          busy;
  logic [LW-1:0] len_count;
  logic          done;
  logic [LW-1:0] len_final;
  logic          length_ok;
  logic          luhn_valid;
  logic          error_flag;
`ifdef LUHN_GEN_EN
  logic [3:0]    check_digit;
`endif

  typedef struct {
    int len;
    int lok;
    int lv;
    int cd;
  } exp_t;

  exp_t exp_q[$];
  int   q_dig[$];
  int   vectors     = 0;
  int   miscompares = 0;

  luhn_stream_engine #(.MIN_DIGITS(MIN_D), .MAX_DIGITS(MAX_D), .LEN_W(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .digit_valid (digit_valid),
    .digit_in    (digit_in),
    .pan_end     (pan_end),
    .abort       (abort),
    .busy        (busy),
    .len_count   (len_count),
    .done        (done),
    .len_final   (len_final),
    .length_ok   (length_ok),
    .luhn_valid  (luhn_valid),
    .error_flag  (error_flag)
`ifdef LUHN_GEN_EN
    ,
    .check_digit (check_digit)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  // Luhn total mod 10: every second digit from the right is doubled.
  function automatic int luhn_sum(input int d[$]);
    int s = 0;
    for (int i = 0; i < d.size(); i++) begin
      int v = d[d.size() - 1 - i];
      if (i % 2 == 1) begin
        v = v * 2;
        if (v > 9) v = v - 9;
      end
      s += v;
    end
    return s % 10;
  endfunction

  // Digit that, appended to d, makes a valid Luhn string.
  function automatic int gen_check(input int d[$]);
    for (int c = 0; c < 10; c++) begin
      int t[$];
      t = d;
      t.push_back(c);
      if (luhn_sum(t) == 0) return c;
    end
    return -1;
  endfunction

  function automatic exp_t model(input int d[$]);
    exp_t e;
    e.len = d.size();
    e.lok = (e.len >= MIN_D && e.len <= MAX_D) ? 1 : 0;
    e.lv  = (e.lok == 1 && luhn_sum(d) == 0) ? 1 : 0;
    e.cd  = gen_check(d);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue start, the digits in q_dig (optional random gaps), and pan_end
  // either on the last digit or in a separate cycle.
  task automatic run_pan(input bit end_sep, input bit gaps);
    int n = q_dig.size();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        digit_valid = 1'b0;
        step();
      end
      digit_valid = 1'b1;
      digit_in    = 4'(q_dig[i]);
      pan_end     = (!end_sep && i == n - 1);
      if (pan_end) exp_q.push_back(model(q_dig));
      step();
    end
    digit_valid = 1'b0;
    pan_end     = 1'b0;
    if (end_sep || n == 0) begin
      pan_end = 1'b1;
      exp_q.push_back(model(q_dig));
      step();
      pan_end = 1'b0;
    end
    step();
    step();
  endtask

  task automatic load_base16(input int last);
    q_dig.delete();
    q_dig.push_back(4);
    for (int i = 0; i < 14; i++) q_dig.push_back(1);
    if (last >= 0) q_dig.push_back(last);
  endtask

  // Scoreboard monitor: compare each done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("len_final", int'(len_final), e.len);
        chk("length_ok", int'(length_ok), e.lok);
        chk("luhn_valid", int'(luhn_valid), e.lv);
`ifdef LUHN_GEN_EN
        chk("check_digit", int'(check_digit), e.cd);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; digit_valid = 1'b0; digit_in = 4'd0;
    pan_end = 1'b0; abort = 1'b0;
    step(); step(); step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_len_count", int'(len_count), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_len_final", int'(len_final), 0);
    chk("rst_length_ok", int'(length_ok), 0);
    chk("rst_luhn_valid", int'(luhn_valid), 0);
    chk("rst_error_flag", int'(error_flag), 0);
    rst = 1'b0;
    step();

    // Known-good 16-digit PAN 4,1x15
    load_base16(1);
    run_pan(1'b0, 1'b0);
    chk("good16_valid", int'(luhn_valid), 1);
    chk("good16_len", int'(len_final), 16);
    chk("good16_busy", int'(busy), 0);

    // Same stream ending in 2
    load_base16(2);
    run_pan(1'b0, 1'b0);
    chk("bad16_valid", int'(luhn_valid), 0);
    chk("bad16_lenok", int'(length_ok), 1);

    // 15-digit payload (check digit 1 when generation is built in)
    load_base16(-1);
    run_pan(1'b1, 1'b0);
    chk("pay15_len", int'(len_final), 15);
`ifdef LUHN_GEN_EN
    chk("pay15_check", int'(check_digit), 1);
`endif

    // Empty PAN
    q_dig.delete();
    run_pan(1'b1, 1'b0);
    chk("empty_lenok", int'(length_ok), 0);

    // Overflow: 20 zeros
    start = 1'b1; step(); start = 1'b0;
    chk("start_busy", int'(busy), 1);
    for (int i = 0; i < 20; i++) begin
      digit_valid = 1'b1; digit_in = 4'd0;
      step();
      if (i == 18) begin
        chk("ovf_len19", int'(len_count), 19);
        chk("ovf_err19", int'(error_flag), 0);
      end
    end
    digit_valid = 1'b0;
    chk("ovf_err", int'(error_flag), 1);
    chk("ovf_len_sat", int'(len_count), 20);
    chk("ovf_busy", int'(busy), 0);
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("ovf_start_clr", int'(error_flag), 0);
    chk("ovf_start_len", int'(len_count), 0);

    // Non-BCD digit on the third position
    digit_valid = 1'b1; digit_in = 4'd5; step();
    digit_in = 4'd6; step();
    digit_in = 4'hA; step();
    digit_valid = 1'b0;
    chk("bcd_err", int'(error_flag), 1);
    chk("bcd_len", int'(len_count), 2);
    chk("bcd_busy", int'(busy), 0);
    pan_end = 1'b1; step(); pan_end = 1'b0;   // no done from ERR
    step();
    abort = 1'b1; step(); abort = 1'b0;

    // Abort after 5 digits, then a valid PAN
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      digit_valid = 1'b1; digit_in = 4'(i + 3); step();
    end
    digit_valid = 1'b0;
    chk("pre_abort_len", int'(len_count), 5);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_len", int'(len_count), 0);
    step(); step();
    load_base16(1);
    run_pan(1'b1, 1'b1);
    chk("post_abort_valid", int'(luhn_valid), 1);

    // Stray digit in IDLE
    digit_valid = 1'b1; digit_in = 4'd3; step(); digit_valid = 1'b0;
    chk("stray_err", int'(error_flag), 1);
    chk("stray_busy", int'(busy), 0);

    // Randomized PANs with random lengths, gaps, pan_end placement, some aborts
    for (int k = 0; k < 40; k++) begin
      int n = $urandom_range(0, MAX_D);
      q_dig.delete();
      for (int i = 0; i < n; i++) q_dig.push_back($urandom_range(0, 9));
      if (n > 0 && $urandom_range(0, 1) == 1) begin
        int c;
        void'(q_dig.pop_back());
        c = gen_check(q_dig);
        q_dig.push_back(c);
      end
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < n; i++) begin
          digit_valid = 1'b1; digit_in = 4'(q_dig[i]); step();
        end
        digit_valid = 1'b0;
        abort = 1'b1; step(); abort = 1'b0;
        chk("rnd_abort_busy", int'(busy), 0);
        step();
      end else begin
        run_pan(1'($urandom_range(0, 1)), 1'b1);
      end
    end

    step(); step();
    chk("pending_expected", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
